elevator_controller: RTL and testbench
======================================

# elevator_controller

Elevator car controller for the floor-display path. It latches floor-call requests from debounced push buttons and schedules car movement with a directional (SCAN) policy. It times floor-to-floor travel and door dwell, and drives the current floor number and motion status. The `seven_segment` display stage consumes these outputs directly: `floor` feeds the floor digit, and `status` selects the direction glyph.

## Interface
- `NUM_FLOORS`, 8: number of floors, numbered 0..NUM_FLOORS-1; legal range 2..10, so the floor fits one display digit.
- `TRAVEL_TICKS`, 50_000_000: clk cycles to travel one floor; must be ≥2.
- `DOOR_TICKS`, 100_000_000: clk cycles the door stays open; must be ≥2.

- `clk`, input, 1: system clock; all state updates on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, NUM_FLOORS: floor-call requests, one bit per floor; a single-cycle pulse is sufficient.
- `floor`, output, 4: current car floor, binary.
- `status`, output, 2: car motion status. 2'd0 = UP, 2'd1 = DOWN, 2'd2 = STABLE. 2'd3 is never driven.
- `door_open`, output, 1: high while the car is in DOOR_OPEN.
- `pending`, output, NUM_FLOORS: latched, not-yet-served requests.
- `estop`, input, 1: emergency stop; exists only with `ELEVATOR_ESTOP_EN` (see Configuration).

## Operation
- **Request latch:** every cycle, `pending <= (pending | req) & ~clear`.
  - `clear` is the served-floor bit.
  - A `req` bit for the current floor during DOOR_OPEN is not latched; it restarts the door timer instead.
- **Direction register `dir`:** 1 = up, 0 = down. Updated on entry to MOVE_UP or MOVE_DOWN.
- **FSM states:** IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- **IDLE**, evaluated in priority order:
  - `pending[floor]` set → DOOR_OPEN, and that bit is cleared.
  - Pending requests both above and below → move in `dir`.
  - Pending only above → MOVE_UP.
  - Pending only below → MOVE_DOWN.
  - Otherwise stay in IDLE.
- **MOVE_UP / MOVE_DOWN:**
  - The timer counts 0..TRAVEL_TICKS-1.
  - At the terminal count, `floor` steps by ±1 and the timer resets.
  - The next state is then chosen from the new floor:
    - New floor pending → DOOR_OPEN, bit cleared.
    - Else a request lies further in the current direction → remain in the move state.
    - Else → IDLE.
- **DOOR_OPEN:**
  - The timer counts 0..DOOR_TICKS-1, then the FSM returns to IDLE.
  - A `req` for the current floor resets the timer to 0.
- **Output decode:** `status` = UP in MOVE_UP, DOWN in MOVE_DOWN, STABLE in IDLE and DOOR_OPEN.
- **Widths:**
  - The timer is sized `$clog2(max(TRAVEL_TICKS, DOOR_TICKS))`.
  - `floor` is zero-extended to 4 bits.
  - `floor` never leaves 0..NUM_FLOORS-1, because requests outside that range do not exist by width.

## Timing
- **Reset values:** `floor`=0, `status`=2'd2, `door_open`=0, `pending`=0, state IDLE, `dir`=up, timer=0.
- **Reset mid-travel:** all reset values apply asynchronously; pending requests are lost.
- **Request latency:** a `req` pulse sampled at edge N appears on `pending` after edge N. The FSM leaves IDLE at edge N+1.
- **Travel rate:** the first floor step occurs TRAVEL_TICKS cycles after entry to the move state; subsequent steps follow every TRAVEL_TICKS cycles.
- **Door assertion:** `door_open` rises on the same edge as the floor step into a served floor. It stays high for exactly DOOR_TICKS cycles, absent restarts.
- **Simultaneous events:**
  - `req` for the floor being arrived at on the arrival edge is served by that arrival.
  - `req` for the floor being departed is latched and served later.
- All outputs are registered; no combinational path from `req` to any output.

## Configuration
- **`ELEVATOR_ESTOP_EN` defined:**
  - The `estop` port exists.
  - While `estop`=1, the move timer holds its value, `floor` does not change, and `status` shows STABLE.
  - The DOOR_OPEN timer is frozen, with `door_open` unchanged.
  - Requests continue to latch.
  - On release, the FSM resumes its prior state, and the timer continues from the held value.
- **Undefined:** no `estop` port; the FSM behaves as if `estop`=0.

## Test plan
Parameters for all scenarios: NUM_FLOORS=8, TRAVEL_TICKS=4, DOOR_TICKS=3.

1. **Reset:** assert `rst_n`=0 asynchronously mid-cycle → outputs immediately `floor`=0, `status`=2, `door_open`=0, `pending`=0.
2. **Single call:** 1-cycle `req`=8'h08 at floor 0 →
   - `pending`=8'h08 next cycle, `status`=0.
   - `floor` steps to 1, 2, 3 at 4-cycle spacing.
   - `door_open`=1 for 3 cycles with `pending`=0, then IDLE with `status`=2.
3. **SCAN ordering:** idle at floor 3 with `dir`=up; `req`=8'h22 (floors 1 and 5) in one cycle →
   - Car serves floor 5 first, then reverses with `status`=1.
   - Car serves floor 1.
4. **Same-floor call:**
   - Idle at floor 2, `req`=8'h04 → `door_open`=1 two edges later, for 3 cycles.
   - Repeat `req`=8'h04 during the door's 2nd cycle → door stays open 3 more cycles.
5. **Reset mid-travel:** at floor 4 with MOVE_UP toward 7, pull `rst_n` low → `floor`=0 and `pending`=0 immediately; no motion after release.
6. **Emergency stop (`ELEVATOR_ESTOP_EN`):** `estop`=1 for 10 cycles during MOVE_UP →
   - `floor` is constant, `status`=2, and a new `req` is latched.
   - After release, the floor step occurs after the remaining timer cycles.

Source files
------------

// File: rtl/elevator_controller.sv
// -----------------------------------------------------------------------------
// elevator_controller
//   Elevator car controller for the floor-display path. Latches floor calls,
//   schedules car movement with a SCAN (keep-going-in-one-direction) policy,
//   times floor-to-floor travel and door dwell, and drives the floor number
//   and motion status for the seven_segment stage.
//
//   Optional feature macro: ELEVATOR_ESTOP_EN adds the estop input, which
//   freezes movement and door timing while held.
//
// Parameters
//   NUM_FLOORS    number of floors (2..10)
//   TRAVEL_TICKS  clk cycles per floor of travel (>=2)
//   DOOR_TICKS    clk cycles the door stays open (>=2)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        floor-call pulses, one bit per floor
//   estop      emergency stop (only with ELEVATOR_ESTOP_EN)
//   floor      current floor, binary
//   status     0 = UP, 1 = DOWN, 2 = STABLE
//   door_open  high while the door is open
//   pending    latched, not-yet-served calls
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | car parked with door closed, choosing the next direction
// MOVE_UP   | travelling upward, one floor every TRAVEL_TICKS cycles
// MOVE_DOWN | travelling downward, one floor every TRAVEL_TICKS cycles
// DOOR_OPEN | serving the current floor for DOOR_TICKS cycles
// -----------------------------------------------------------------------------
module elevator_controller #(
   parameter int NUM_FLOORS   = 8,
   parameter int TRAVEL_TICKS = 50_000_000,
   parameter int DOOR_TICKS   = 100_000_000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_FLOORS-1:0] req,
`ifdef ELEVATOR_ESTOP_EN
   input  logic                  estop,
`endif
   output logic [3:0]            floor,
   output logic [1:0]            status,
   output logic                  door_open,
   output logic [NUM_FLOORS-1:0] pending
);

   localparam int MAX_TICKS = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
   localparam int TW        = $clog2(MAX_TICKS);

   localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
   localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_TICKS - 1);

   localparam logic [1:0] ST_UP     = 2'd0;
   localparam logic [1:0] ST_DOWN   = 2'd1;
   localparam logic [1:0] ST_STABLE = 2'd2;

   typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

   state_t          state;
   logic            dir;
   logic [TW-1:0]   timer;

   logic            halt;
   logic [3:0]      step_floor;
   logic [NUM_FLOORS-1:0] here_mask, above_mask, below_mask;
   logic [NUM_FLOORS-1:0] step_mask, step_above, step_below;
   logic [NUM_FLOORS-1:0] pend_all, req_eff, clear;
   logic            at_here, any_above, any_below;
   logic            arrive_hit, further_up, further_down;
   logic            tc_travel, tc_door, door_restart;

`ifdef ELEVATOR_ESTOP_EN
   assign halt = estop;
`else
   assign halt = 1'b0;
`endif

   // Floor the car lands on at the next travel terminal count; only
   // meaningful in the move states, where it can never leave range.
   assign step_floor = (state == MOVE_UP) ? floor + 4'd1 : floor - 4'd1;

   always_comb begin
      here_mask  = '0;
      above_mask = '0;
      below_mask = '0;
      step_mask  = '0;
      step_above = '0;
      step_below = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         here_mask[i]  = (4'(i) == floor);
         above_mask[i] = (4'(i) >  floor);
         below_mask[i] = (4'(i) <  floor);
         step_mask[i]  = (4'(i) == step_floor);
         step_above[i] = (4'(i) >  step_floor);
         step_below[i] = (4'(i) <  step_floor);
      end
   end

   // Arrival decisions include this cycle's req so a call for the floor
   // being reached on the arrival edge is served by that arrival.
   assign pend_all     = pending | req;
   assign at_here      = |(pending & here_mask);
   assign any_above    = |(pending & above_mask);
   assign any_below    = |(pending & below_mask);
   assign arrive_hit   = |(pend_all & step_mask);
   assign further_up   = |(pend_all & step_above);
   assign further_down = |(pend_all & step_below);
   assign tc_travel    = (timer == TRAVEL_LAST);
   assign tc_door      = (timer == DOOR_LAST);
   assign door_restart = (state == DOOR_OPEN) && |(req & here_mask);

   always_comb begin
      clear   = '0;
      req_eff = req;
      // A call for the floor whose door is open is absorbed, not latched.
      if (state == DOOR_OPEN)
         req_eff = req & ~here_mask;
      if (!halt) begin
         if (state == IDLE && at_here)
            clear = here_mask;
         else if ((state == MOVE_UP || state == MOVE_DOWN) && tc_travel && arrive_hit)
            clear = step_mask;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         dir       <= 1'b1;
         timer     <= '0;
         floor     <= 4'd0;
         status    <= ST_STABLE;
         door_open <= 1'b0;
         pending   <= '0;
      end else begin
         pending <= (pending | req_eff) & ~clear;
         if (halt) begin
            status <= ST_STABLE;
         end else begin
            case (state)
               IDLE: begin
                  timer <= '0;
                  if (at_here) begin
                     state     <= DOOR_OPEN;
                     door_open <= 1'b1;
                     status    <= ST_STABLE;
                  end else if (any_above && (dir || !any_below)) begin
                     state  <= MOVE_UP;
                     dir    <= 1'b1;
                     status <= ST_UP;
                  end else if (any_below) begin
                     state  <= MOVE_DOWN;
                     dir    <= 1'b0;
                     status <= ST_DOWN;
                  end
               end
               MOVE_UP, MOVE_DOWN: begin
                  // Re-assert the move glyph every cycle so it returns
                  // straight after an emergency stop releases.
                  status <= (state == MOVE_UP) ? ST_UP : ST_DOWN;
                  if (tc_travel) begin
                     floor <= step_floor;
                     timer <= '0;
                     if (arrive_hit) begin
                        state     <= DOOR_OPEN;
                        door_open <= 1'b1;
                        status    <= ST_STABLE;
                     end else if (!((state == MOVE_UP) ? further_up : further_down)) begin
                        state  <= IDLE;
                        status <= ST_STABLE;
                     end
                  end else begin
                     timer <= timer + TW'(1);
                  end
               end
               DOOR_OPEN: begin
                  status <= ST_STABLE;
                  if (door_restart) begin
                     timer <= '0;
                  end else if (tc_door) begin
                     state     <= IDLE;
                     door_open <= 1'b0;
                     timer     <= '0;
                  end else begin
                     timer <= timer + TW'(1);
                  end
               end
               default: begin
                  state     <= IDLE;
                  timer     <= '0;
                  door_open <= 1'b0;
                  status    <= ST_STABLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_elevator_controller.sv
module tb_elevator_controller;

   localparam int NF     = 8;
   localparam int TRAVEL = 4;
   localparam int DOOR   = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [NF-1:0] req = '0;
   logic          estop = 1'b0;
   logic [3:0]    floor;
   logic [1:0]    status;
   logic          door_open;
   logic [NF-1:0] pending;

   int total = 0;
   int bad   = 0;

   elevator_controller #(
      .NUM_FLOORS  (NF),
      .TRAVEL_TICKS(TRAVEL),
      .DOOR_TICKS  (DOOR)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
`ifdef ELEVATOR_ESTOP_EN
      .estop    (estop),
`endif
      .floor    (floor),
      .status   (status),
      .door_open(door_open),
      .pending  (pending)
   );

   always #5 clk = ~clk;

   // Behavioural model: mode 0 parked, 1 going up, 2 going down, 3 door open.
   // "left" counts the cycles remaining in the current travel leg or dwell.
   logic [NF-1:0] m_pend;
   int            m_floor, m_left, m_mode, m_stat;
   bit            m_dir;

   always @(posedge clk or negedge rst_n) begin : model
      logic [NF-1:0] p, r, pr, clr, bit_f;
      int f, left, mode;
      bit d, above, below, further;
      if (!rst_n) begin
         m_pend  <= '0;
         m_floor <= 0;
         m_left  <= 0;
         m_mode  <= 0;
         m_stat  <= 2;
         m_dir   <= 1'b1;
      end else begin
         p = m_pend; r = req; f = m_floor; left = m_left; mode = m_mode; d = m_dir;
         clr = '0;
         bit_f = 8'h1 << f;
         if (mode == 3) r = r & ~bit_f;
         if (!estop) begin
            case (mode)
               0: begin
                  if ((p & bit_f) != 8'h0) begin
                     mode = 3; left = DOOR; clr = bit_f;
                  end else begin
                     above = (p >> (f + 1)) != 8'h0;
                     below = (p & (bit_f - 8'h1)) != 8'h0;
                     if (above && (d || !below)) begin
                        mode = 1; d = 1'b1; left = TRAVEL;
                     end else if (below) begin
                        mode = 2; d = 1'b0; left = TRAVEL;
                     end
                  end
               end
               1, 2: begin
                  left = left - 1;
                  if (left == 0) begin
                     f = (mode == 1) ? f + 1 : f - 1;
                     left = TRAVEL;
                     pr = p | req;
                     bit_f = 8'h1 << f;
                     if (mode == 1) further = (pr >> (f + 1)) != 8'h0;
                     else           further = (pr & (bit_f - 8'h1)) != 8'h0;
                     if ((pr & bit_f) != 8'h0) begin
                        mode = 3; left = DOOR; clr = bit_f;
                     end else if (!further) begin
                        mode = 0;
                     end
                  end
               end
               default: begin
                  if ((req & bit_f) != 8'h0) left = DOOR;
                  else begin
                     left = left - 1;
                     if (left == 0) mode = 0;
                  end
               end
            endcase
         end
         m_pend  <= (p | r) & ~clr;
         m_floor <= f;
         m_left  <= left;
         m_mode  <= mode;
         m_dir   <= d;
         m_stat  <= estop ? 2 : (mode == 1 ? 0 : (mode == 2 ? 1 : 2));
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk("cyc_floor",   32'(floor),     32'(m_floor));
         chk("cyc_status",  32'(status),    32'(m_stat));
         chk("cyc_door",    32'(door_open), 32'(m_mode == 3));
         chk("cyc_pending", 32'(pending),   32'(m_pend));
      end
   end

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic pulse(input logic [NF-1:0] r);
      req = r;
      @(negedge clk);
      req = '0;
      #1;
   endtask

   initial begin
      wait_n(3);
      rst_n = 1'b1;
      wait_n(2);

      // 1: asynchronous reset mid-cycle while a call is being served
      pulse(8'h80);
      wait_n(1);
      chk("pre_rst_status", 32'(status), 32'd0);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("rst_floor",   32'(floor),     32'd0);
      chk("rst_status",  32'(status),    32'd2);
      chk("rst_door",    32'(door_open), 32'd0);
      chk("rst_pending", 32'(pending),   32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_n(2);

      // 2: single call to floor 3 from floor 0
      pulse(8'h08);
      chk("t2_pending",  32'(pending), 32'h08);
      chk("t2_idle",     32'(status),  32'd2);
      wait_n(1);
      chk("t2_up",       32'(status),  32'd0);
      wait_n(4);
      chk("t2_floor1",   32'(floor),   32'd1);
      wait_n(3);
      chk("t2_hold1",    32'(floor),   32'd1);
      wait_n(1);
      chk("t2_floor2",   32'(floor),   32'd2);
      wait_n(4);
      chk("t2_floor3",   32'(floor),   32'd3);
      chk("t2_door",     32'(door_open), 32'd1);
      chk("t2_served",   32'(pending), 32'h0);
      wait_n(2);
      chk("t2_door_end", 32'(door_open), 32'd1);
      wait_n(1);
      chk("t2_closed",   32'(door_open), 32'd0);
      chk("t2_stable",   32'(status),  32'd2);

      // 3: SCAN from floor 3 with calls at 1 and 5, heading up
      pulse(8'h22);
      wait_n(1);
      chk("t3_up_first", 32'(status), 32'd0);
      wait_n(8);
      chk("t3_floor5",   32'(floor),     32'd5);
      chk("t3_door5",    32'(door_open), 32'd1);
      chk("t3_left1",    32'(pending),   32'h02);
      wait_n(4);
      chk("t3_reverse",  32'(status), 32'd1);
      wait_n(16);
      chk("t3_floor1",   32'(floor),     32'd1);
      chk("t3_door1",    32'(door_open), 32'd1);
      chk("t3_empty",    32'(pending),   32'h0);
      wait_n(3);

      // 4: same-floor call at floor 2, then a restart of the dwell
      pulse(8'h04);
      wait_n(8);
      chk("t4_at2",      32'(floor), 32'd2);
      pulse(8'h04);
      chk("t4_not_yet",  32'(door_open), 32'd0);
      wait_n(1);
      chk("t4_open",     32'(door_open), 32'd1);
      wait_n(1);
      pulse(8'h04);
      chk("t4_absorbed", 32'(pending),   32'h0);
      chk("t4_still",    32'(door_open), 32'd1);
      wait_n(2);
      chk("t4_extended", 32'(door_open), 32'd1);
      wait_n(1);
      chk("t4_closed",   32'(door_open), 32'd0);

      // 5: reset while travelling up from floor 4 toward 7
      pulse(8'h80);
      wait_n(10);
      chk("t5_floor4",   32'(floor),  32'd4);
      chk("t5_moving",   32'(status), 32'd0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_floor", 32'(floor),   32'd0);
      chk("t5_rst_pend",  32'(pending), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_n(12);
      chk("t5_parked",   32'(floor),  32'd0);
      chk("t5_no_move",  32'(status), 32'd2);

`ifdef ELEVATOR_ESTOP_EN
      // 6: emergency stop for 10 cycles during the first travel leg
      pulse(8'h08);
      wait_n(2);
      estop = 1'b1;
      wait_n(5);
      pulse(8'h40);
      chk("t6_latched",  32'(pending), 32'h48);
      chk("t6_frozen",   32'(floor),   32'd0);
      chk("t6_stable",   32'(status),  32'd2);
      wait_n(4);
      estop = 1'b0;
      wait_n(1);
      chk("t6_resume",   32'(status), 32'd0);
      wait_n(1);
      chk("t6_remain",   32'(floor),  32'd0);
      wait_n(1);
      chk("t6_step",     32'(floor),  32'd1);
      wait_n(30);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
